// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle RV32I controller and its datapath.
// Handshake: the datapath drives mem_ready high in the cycle the shared
// memory completes the access currently addressed; the controller holds
// its memory outputs (AdrSrc, MemWrite) stable in FETCH, MEMREAD and
// MEMWRITE until that cycle, and ignores mem_ready in every other state.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [3:0] flags;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       illegal;
    logic [3:0] state;

    // Controller side
    modport master (
        input  op, funct3, funct7b5, flags, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, RegWrite, ImmSrc, ALUControl, illegal, state
    );

    // Datapath side
    modport slave (
        output op, funct3, funct7b5, flags, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, RegWrite, ImmSrc, ALUControl, illegal, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory and
// writeback over 3-5 cycles, stalling on the memory-ready handshake.
module multicycle_controller #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        JALLINK  = 4'd12,
        UPPER    = 4'd13
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    state_t     state_q, state_d;
    logic       mem_rdy;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic       taken;
    logic [3:0] alu_dec;
    logic [2:0] imm_src;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [3:0] alu_control;

    // With wait states disabled the memory is assumed to always complete
    assign mem_rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
    assign {flag_n, flag_z, flag_c, flag_v} = bus.flags;

    // State register; reset returns to FETCH from anywhere
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        imm_src = 3'b000;
        case (bus.op)
            7'b0000011, 7'b0010011, 7'b1100111: imm_src = 3'b000;
            7'b0100011:                         imm_src = 3'b001;
            7'b1100011:                         imm_src = 3'b010;
            7'b1101111:                         imm_src = 3'b011;
            7'b0110111, 7'b0010111:             imm_src = 3'b100;
            default:                            imm_src = 3'b000;
        endcase
    end

    // ALU operation from funct3; sub only exists for register-register ops
    always_comb begin
        alu_dec = ALU_ADD;
        case (bus.funct3)
            3'b000: alu_dec = (state_q == EXECUTER && bus.funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_dec = ALU_SLL;
            3'b010: alu_dec = ALU_SLT;
            3'b011: alu_dec = ALU_SLTU;
            3'b100: alu_dec = ALU_XOR;
            3'b101: alu_dec = bus.funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_dec = ALU_OR;
            3'b111: alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    end

    // Branch resolution from the flags of A - B; C set means no borrow
    always_comb begin
        taken = 1'b0;
        case (bus.funct3)
            3'b000:  taken = flag_z;
            3'b001:  taken = !flag_z;
            3'b100:  taken = flag_n ^ flag_v;
            3'b101:  taken = !(flag_n ^ flag_v);
            3'b110:  taken = !flag_c;
            3'b111:  taken = flag_c;
            default: taken = 1'b0;
        endcase
    end

    // Next state and per-state control outputs; reset masks all write enables
    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        illegal     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;

        case (state_q)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_rdy;
                pc_write   = mem_rdy;
                if (mem_rdy) state_d = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.op)
                    7'b0000011, 7'b0100011: state_d = MEMADR;
                    7'b0110011:             state_d = EXECUTER;
                    7'b0010011:             state_d = EXECUTEI;
                    7'b1100011:             state_d = BRANCH;
                    7'b1101111:             state_d = JAL;
                    7'b1100111:             state_d = JALR;
                    7'b0110111, 7'b0010111: state_d = UPPER;
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = bus.op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (mem_rdy) state_d = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_rdy) state_d = FETCH;
            end
            EXECUTER: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b00;
                alu_control = alu_dec;
                state_d     = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_dec;
                state_d     = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = taken;
                state_d     = FETCH;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = ALUWB;
            end
            JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
                state_d    = JALLINK;
            end
            JALLINK: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = ALUWB;
            end
            UPPER: begin
                alu_src_a = bus.op[5] ? 2'b11 : 2'b01;
                alu_src_b = 2'b01;
                state_d   = ALUWB;
            end
            default: state_d = FETCH;
        endcase

        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign bus.PCWrite    = pc_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.MemWrite   = mem_write;
    assign bus.IRWrite    = ir_write;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.RegWrite   = reg_write;
    assign bus.ImmSrc     = imm_src;
    assign bus.ALUControl = alu_control;
    assign bus.illegal    = illegal;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction-level reference model that
// expands each instruction into its per-cycle phase list, pushes expected
// control vectors into a queue, and a monitor compares every cycle.
module tb_multicycle_controller;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3,
                   P_MEMWB = 4, P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7,
                   P_ALUWB = 8, P_BRANCH = 9, P_JAL = 10, P_JALR = 11,
                   P_JALLINK = 12, P_UPPER = 13;

    localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4, C_JAL = 5,
                   C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_ILL = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   cyc_no = 0;
    logic [22:0] exp_q[$];

    multicycle_controller_if bus();

    multicycle_controller #(.MEM_WAIT_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1, "timeout");
    end

    function automatic bit is_legal(input logic [6:0] op);
        return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
               op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111 ||
               op == 7'b1100111 || op == 7'b0110111 || op == 7'b0010111;
    endfunction

    function automatic logic [6:0] op_of(input int cls);
        case (cls)
            C_R:     return 7'b0110011;
            C_I:     return 7'b0010011;
            C_LW:    return 7'b0000011;
            C_SW:    return 7'b0100011;
            C_BR:    return 7'b1100011;
            C_JAL:   return 7'b1101111;
            C_JALR:  return 7'b1100111;
            C_LUI:   return 7'b0110111;
            C_AUIPC: return 7'b0010111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f7, input bit is_r);
        case (f3)
            3'd0: return (is_r && f7) ? 4'b0001 : 4'b0000;
            3'd1: return 4'b0111;
            3'd2: return 4'b0101;
            3'd3: return 4'b0110;
            3'd4: return 4'b0100;
            3'd5: return f7 ? 4'b1001 : 4'b1000;
            3'd6: return 4'b0011;
            default: return 4'b0010;
        endcase
    endfunction

    // Expected control vector for one cycle of a given phase
    function automatic logic [22:0] exp_of(input int ph, input logic [6:0] op,
                                           input logic [2:0] f3, input logic f7,
                                           input logic mr, input logic rst,
                                           input logic taken);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, asa, asb;
        logic [2:0] imm;
        logic [3:0] alu;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        rs = 0; asa = 0; asb = 0; alu = 0; imm = 3'b000;
        if (op == 7'b0100011) imm = 3'b001;
        else if (op == 7'b1100011) imm = 3'b010;
        else if (op == 7'b1101111) imm = 3'b011;
        else if (op == 7'b0110111 || op == 7'b0010111) imm = 3'b100;
        case (ph)
            P_FETCH:    begin asb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
            P_DECODE:   begin asa = 2'b01; asb = 2'b01; ill = !is_legal(op); end
            P_MEMADR:   begin asa = 2'b10; asb = 2'b01; end
            P_MEMREAD:  adr = 1;
            P_MEMWB:    begin rs = 2'b01; rw = 1; end
            P_MEMWRITE: begin adr = 1; mw = 1; end
            P_EXECR:    begin asa = 2'b10; alu = alu_of(f3, f7, 1); end
            P_EXECI:    begin asa = 2'b10; asb = 2'b01; alu = alu_of(f3, f7, 0); end
            P_ALUWB:    rw = 1;
            P_BRANCH:   begin asa = 2'b10; alu = 4'b0001; pcw = taken; end
            P_JAL:      begin asa = 2'b01; asb = 2'b10; pcw = 1; end
            P_JALR:     begin asa = 2'b10; asb = 2'b01; rs = 2'b10; pcw = 1; end
            P_JALLINK:  begin asa = 2'b01; asb = 2'b10; end
            P_UPPER:    begin asa = op[5] ? 2'b11 : 2'b01; asb = 2'b01; end
            default:    ;
        endcase
        if (rst) begin pcw = 0; irw = 0; rw = 0; mw = 0; ill = 0; end
        return {ph[3:0], pcw, adr, mw, irw, rs, asa, asb, rw, imm, alu, ill};
    endfunction

    // Monitor: compare the DUT's outputs against the oldest expectation
    always @(negedge clk) begin
        logic [22:0] e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {bus.state, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                 bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite,
                 bus.ImmSrc, bus.ALUControl, bus.illegal};
            n_checks++;
            if (g === e) n_pass++;
            else begin
                n_fail++;
                $display("FAIL ctl_vec cycle=%0d got=%06h required=%06h (state got %0d required %0d)",
                         cyc_no, g, e, g[22:19], e[22:19]);
            end
        end
    end

    // Push one expected vector and advance one clock
    task automatic cyc(input int ph, input logic taken);
        exp_q.push_back(exp_of(ph, bus.op, bus.funct3, bus.funct7b5, bus.mem_ready, reset, taken));
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    // Run one instruction; fw/mw are fetch/memory wait cycles; rst_at is
    // the phase index at which reset is asserted (-1 for none)
    task automatic run_instr(input int cls, input logic [2:0] f3, input logic f7,
                             input logic [31:0] a, input logic [31:0] b,
                             input int fw, input int mw, input int rst_at,
                             input logic [6:0] ill_op);
        int   ph_q[$];
        logic mr_q[$];
        logic [32:0] sum;
        logic n, z, c, v, taken;
        for (int i = 0; i < fw; i++) begin ph_q.push_back(P_FETCH); mr_q.push_back(0); end
        ph_q.push_back(P_FETCH);  mr_q.push_back(1);
        ph_q.push_back(P_DECODE); mr_q.push_back($urandom_range(0, 1));
        case (cls)
            C_LW, C_SW: begin
                ph_q.push_back(P_MEMADR); mr_q.push_back($urandom_range(0, 1));
                for (int i = 0; i < mw; i++) begin
                    ph_q.push_back(cls == C_LW ? P_MEMREAD : P_MEMWRITE); mr_q.push_back(0);
                end
                ph_q.push_back(cls == C_LW ? P_MEMREAD : P_MEMWRITE); mr_q.push_back(1);
                if (cls == C_LW) begin ph_q.push_back(P_MEMWB); mr_q.push_back($urandom_range(0, 1)); end
            end
            C_R:     ph_q.push_back(P_EXECR);
            C_I:     ph_q.push_back(P_EXECI);
            C_BR:    ph_q.push_back(P_BRANCH);
            C_JAL:   ph_q.push_back(P_JAL);
            C_JALR:  begin ph_q.push_back(P_JALR); ph_q.push_back(P_JALLINK); end
            C_LUI, C_AUIPC: ph_q.push_back(P_UPPER);
            default: ;
        endcase
        if (cls == C_R || cls == C_I || cls == C_JAL || cls == C_JALR ||
            cls == C_LUI || cls == C_AUIPC) ph_q.push_back(P_ALUWB);
        while (mr_q.size() < ph_q.size()) mr_q.push_back($urandom_range(0, 1));

        // Flags of a - b, and the branch outcome from plain comparisons
        sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
        c = sum[32]; n = sum[31]; z = (sum[31:0] == 32'd0);
        v = (a[31] != b[31]) && (sum[31] != a[31]);
        case (f3)
            3'd0: taken = (a == b);
            3'd1: taken = (a != b);
            3'd4: taken = ($signed(a) < $signed(b));
            3'd5: taken = ($signed(a) >= $signed(b));
            3'd6: taken = (a < b);
            3'd7: taken = (a >= b);
            default: taken = 0;
        endcase

        bus.op = (cls == C_ILL) ? ill_op : op_of(cls);
        bus.funct3 = f3;
        bus.funct7b5 = f7;
        for (int i = 0; i < ph_q.size(); i++) begin
            bus.mem_ready = mr_q[i];
            bus.flags = (ph_q[i] == P_BRANCH) ? {n, z, c, v} : 4'($urandom_range(0, 15));
            if (i == rst_at) reset = 1'b1;
            cyc(ph_q[i], taken);
            if (reset) begin
                reset = 1'b0;
                return;
            end
        end
    endtask

    // Stimulus
    initial begin
        logic [6:0] rop;
        logic [31:0] ra, rb;
        int cls, rst_at;
        bus.op = 7'b0110011; bus.funct3 = 0; bus.funct7b5 = 0;
        bus.flags = 0; bus.mem_ready = 1;
        reset = 1'b1;
        @(posedge clk); #1;
        // Second reset cycle: FETCH with all write enables masked
        cyc(P_FETCH, 1'b0);
        reset = 1'b0;

        // Directed cases
        run_instr(C_R,    3'd0, 1'b1, 0, 0, 0, 0, -1, 0);            // sub
        run_instr(C_LW,   3'd2, 1'b0, 0, 0, 0, 3, -1, 0);            // lw, 3 waits
        run_instr(C_BR,   3'd4, 1'b0, 32'hffffffff, 0, 0, 0, -1, 0); // blt taken
        run_instr(C_BR,   3'd5, 1'b0, 32'h80000000, 1, 0, 0, -1, 0); // bge overflow
        run_instr(C_BR,   3'd7, 1'b0, 5, 5, 0, 0, -1, 0);            // bgeu, C=1
        run_instr(C_BR,   3'd2, 1'b0, 5, 5, 0, 0, -1, 0);            // never taken
        run_instr(C_JALR, 3'd0, 1'b0, 0, 0, 0, 0, -1, 0);
        run_instr(C_ILL,  3'd0, 1'b0, 0, 0, 0, 0, -1, 7'h7f);
        run_instr(C_SW,   3'd2, 1'b0, 0, 0, 0, 2, 4, 0);             // reset in MEMWRITE stall
        run_instr(C_LUI,  3'd0, 1'b0, 0, 0, 2, 0, -1, 0);            // fetch waits
        run_instr(C_AUIPC, 3'd0, 1'b0, 0, 0, 0, 0, -1, 0);
        run_instr(C_I,    3'd0, 1'b1, 0, 0, 0, 0, -1, 0);            // addi ignores funct7b5
        run_instr(C_JAL,  3'd0, 1'b0, 0, 0, 0, 0, -1, 0);

        // Randomized instruction stream
        for (int k = 0; k < 250; k++) begin
            cls = $urandom_range(0, 9);
            rop = 7'($urandom_range(0, 127));
            while (is_legal(rop)) rop = 7'($urandom_range(0, 127));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ 32'h80000000;
                2: rb = 32'($urandom_range(0, 3));
                default: rb = $urandom;
            endcase
            rst_at = ($urandom_range(0, 12) == 0) ? $urandom_range(0, 6) : -1;
            run_instr(cls, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ra, rb,
                      $urandom_range(0, 2), $urandom_range(0, 3), rst_at, rop);
        end

        @(posedge clk); #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else begin
            n_fail++;
            $display("FAIL exp_q_drain got=%0d required=0 pending entries", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
